// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the CPU-side interrupt sequencer:
// the FSM state encoding, the default vectors and the int_status bit layout.
package interrupt_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOW_ACT   = 2'd1,
    ST_HIGH_ACT  = 2'd2,
    ST_HIGH_NEST = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_HIGH_VECTOR = 32'h0000_0008;
  localparam logic [31:0] DEFAULT_LOW_VECTOR  = 32'h0000_0018;

  // int_status bit positions, as seen by firmware in int_reg[21:18]
  localparam int STAT_NESTED   = 3;
  localparam int STAT_LOW_PEND = 2;
  localparam int STAT_HIGH_ACT = 1;
  localparam int STAT_LOW_ACT  = 0;

  function automatic logic [3:0] status_decode(input state_t s, input logic pend);
    logic [3:0] st;
    st                = 4'b0000;
    st[STAT_NESTED]   = (s == ST_HIGH_NEST);
    st[STAT_LOW_PEND] = pend;
    st[STAT_HIGH_ACT] = (s == ST_HIGH_ACT) || (s == ST_HIGH_NEST);
    st[STAT_LOW_ACT]  = (s == ST_LOW_ACT) || (s == ST_HIGH_NEST);
    return st;
  endfunction

endpackage

// File: rtl/interrupt_sequencer.sv
// Takes interrupt requests at instruction boundaries, redirects fetch to the
// high/low vector, and restores return PCs with one level of high-over-low nesting.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter logic [31:0] HIGH_VECTOR = DEFAULT_HIGH_VECTOR,
  parameter logic [31:0] LOW_VECTOR  = DEFAULT_LOW_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        interrupt_pin_high,
  input  logic        interrupt_pin_low,
  input  logic        instr_done,
  input  logic        reti,
  input  logic [31:0] pc_next,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        ack_high,
  output logic        ack_low,
  output logic        spurious_reti,
  output logic [3:0]  int_status
);

  state_t      state, state_nxt;
  logic        low_pending, pend_nxt;
  logic [31:0] saved_pc_low, saved_pc_high;
  logic [31:0] spc_low_nxt, spc_high_nxt, rpc_nxt;
  logic        redir_nxt, ack_h_nxt, ack_l_nxt, spur_nxt;
  logic        sample;

  // The instruction at the redirect target has not executed yet, so a
  // retirement strobe coinciding with redirect is not a boundary.
  assign sample = instr_done && !redirect;

  always_comb begin
    state_nxt    = state;
    pend_nxt     = low_pending;
    spc_low_nxt  = saved_pc_low;
    spc_high_nxt = saved_pc_high;
    rpc_nxt      = redirect_pc;
    redir_nxt    = 1'b0;
    ack_h_nxt    = 1'b0;
    ack_l_nxt    = 1'b0;
    spur_nxt     = 1'b0;
    if (sample) begin
      if (reti) begin
        case (state)
          ST_LOW_ACT: begin
            state_nxt = ST_IDLE;
            rpc_nxt   = saved_pc_low;
            redir_nxt = 1'b1;
          end
          ST_HIGH_ACT: begin
            state_nxt = ST_IDLE;
            pend_nxt  = 1'b0;
            rpc_nxt   = saved_pc_high;
            redir_nxt = 1'b1;
          end
          ST_HIGH_NEST: begin
            state_nxt = ST_LOW_ACT;
            pend_nxt  = 1'b0;
            rpc_nxt   = saved_pc_high;
            redir_nxt = 1'b1;
          end
          default: spur_nxt = 1'b1;
        endcase
      end else if (interrupt_pin_high && (state == ST_IDLE || state == ST_LOW_ACT)) begin
        state_nxt    = (state == ST_IDLE) ? ST_HIGH_ACT : ST_HIGH_NEST;
        spc_high_nxt = pc_next;
        rpc_nxt      = HIGH_VECTOR;
        redir_nxt    = 1'b1;
        ack_h_nxt    = 1'b1;
      end else if (interrupt_pin_low) begin
        case (state)
          ST_IDLE: begin
            state_nxt   = ST_LOW_ACT;
            pend_nxt    = 1'b0;
            spc_low_nxt = pc_next;
            rpc_nxt     = LOW_VECTOR;
            redir_nxt   = 1'b1;
            ack_l_nxt   = 1'b1;
          end
          ST_HIGH_ACT, ST_HIGH_NEST: pend_nxt = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      low_pending   <= 1'b0;
      saved_pc_low  <= 32'h0;
      saved_pc_high <= 32'h0;
      redirect      <= 1'b0;
      redirect_pc   <= 32'h0;
      ack_high      <= 1'b0;
      ack_low       <= 1'b0;
      spurious_reti <= 1'b0;
      int_status    <= 4'b0000;
    end else begin
      state         <= state_nxt;
      low_pending   <= pend_nxt;
      saved_pc_low  <= spc_low_nxt;
      saved_pc_high <= spc_high_nxt;
      redirect      <= redir_nxt;
      redirect_pc   <= rpc_nxt;
      ack_high      <= ack_h_nxt;
      ack_low       <= ack_l_nxt;
      spurious_reti <= spur_nxt;
      int_status    <= status_decode(state_nxt, pend_nxt);
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: entry, nesting, deferral,
// spurious return, redirect-cycle masking and asynchronous reset.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        interrupt_pin_high = 1'b0;
  logic        interrupt_pin_low = 1'b0;
  logic        instr_done = 1'b0;
  logic        reti = 1'b0;
  logic [31:0] pc_next = 32'h0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ack_high;
  logic        ack_low;
  logic        spurious_reti;
  logic [3:0]  int_status;

  int tests_run = 0;
  int tests_failed = 0;

  interrupt_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .interrupt_pin_high(interrupt_pin_high), .interrupt_pin_low(interrupt_pin_low),
    .instr_done(instr_done), .reti(reti), .pc_next(pc_next),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ack_high(ack_high), .ack_low(ack_low),
    .spurious_reti(spurious_reti), .int_status(int_status)
  );

  always #5 clk = ~clk;

  // One retirement strobe; returns 1 ns after the capturing edge.
  task automatic retire(input logic r, input logic [31:0] pc);
    instr_done = 1'b1;
    reti       = r;
    pc_next    = pc;
    @(posedge clk); #1;
    instr_done = 1'b0;
    reti       = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || ack_high !== 1'b0 || ack_low !== 1'b0 ||
        spurious_reti !== 1'b0 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset: redirect=%b pc=%h ackh=%b ackl=%b spur=%b st=%b, want all zero",
               redirect, redirect_pc, ack_high, ack_low, spurious_reti, int_status);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();
  endtask

  task automatic test_low_entry();
    interrupt_pin_low = 1'b1;
    retire(1'b0, 32'h100);
    interrupt_pin_low = 1'b0;
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h18 || ack_low !== 1'b1 || ack_high !== 1'b0 ||
        int_status !== 4'b0001) begin
      tests_failed++;
      $display("FAIL low_entry: redirect=%b pc=%h ackl=%b ackh=%b st=%b, want 1 00000018 1 0 0001",
               redirect, redirect_pc, ack_low, ack_high, int_status);
    end
    idle_cycle();
    tests_run++;
    if (redirect !== 1'b0 || ack_low !== 1'b0 || redirect_pc !== 32'h18) begin
      tests_failed++;
      $display("FAIL low_entry_pulse: redirect=%b ackl=%b pc=%h, want 0 0 00000018",
               redirect, ack_low, redirect_pc);
    end
  endtask

  task automatic test_nesting();
    interrupt_pin_high = 1'b1;
    retire(1'b0, 32'h40);
    interrupt_pin_high = 1'b0;
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h08 || ack_high !== 1'b1 || int_status !== 4'b1011) begin
      tests_failed++;
      $display("FAIL nest_entry: redirect=%b pc=%h ackh=%b st=%b, want 1 00000008 1 1011",
               redirect, redirect_pc, ack_high, int_status);
    end
    idle_cycle();
    retire(1'b1, 32'h0C);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h40 || int_status !== 4'b0001) begin
      tests_failed++;
      $display("FAIL nest_reti1: redirect=%b pc=%h st=%b, want 1 00000040 0001",
               redirect, redirect_pc, int_status);
    end
    idle_cycle();
    retire(1'b1, 32'h44);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h100 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL nest_reti2: redirect=%b pc=%h st=%b, want 1 00000100 0000",
               redirect, redirect_pc, int_status);
    end
    idle_cycle();
  endtask

  task automatic test_both_pins();
    interrupt_pin_high = 1'b1;
    interrupt_pin_low  = 1'b1;
    retire(1'b0, 32'h80);
    tests_run++;
    if (redirect_pc !== 32'h08 || ack_high !== 1'b1 || ack_low !== 1'b0 || int_status !== 4'b0010) begin
      tests_failed++;
      $display("FAIL both_pins: pc=%h ackh=%b ackl=%b st=%b, want 00000008 1 0 0010",
               redirect_pc, ack_high, ack_low, int_status);
    end
    interrupt_pin_high = 1'b0;
    idle_cycle();
    retire(1'b0, 32'h0C);
    tests_run++;
    if (redirect !== 1'b0 || int_status !== 4'b0110) begin
      tests_failed++;
      $display("FAIL low_pending: redirect=%b st=%b, want 0 0110", redirect, int_status);
    end
    retire(1'b1, 32'h10);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h80 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL high_reti: redirect=%b pc=%h st=%b, want 1 00000080 0000",
               redirect, redirect_pc, int_status);
    end
    idle_cycle();
    retire(1'b0, 32'h90);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h18 || ack_low !== 1'b1 || int_status !== 4'b0001) begin
      tests_failed++;
      $display("FAIL low_after_high: redirect=%b pc=%h ackl=%b st=%b, want 1 00000018 1 0001",
               redirect, redirect_pc, ack_low, int_status);
    end
    interrupt_pin_low = 1'b0;
    idle_cycle();
    retire(1'b1, 32'h20);
    tests_run++;
    if (redirect_pc !== 32'h90 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL low_reti: pc=%h st=%b, want 00000090 0000", redirect_pc, int_status);
    end
    idle_cycle();
  endtask

  task automatic test_deferred_high();
    interrupt_pin_low = 1'b1;
    retire(1'b0, 32'h200);
    interrupt_pin_low = 1'b0;
    idle_cycle();
    interrupt_pin_high = 1'b1;
    retire(1'b1, 32'h1C);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h200 || ack_high !== 1'b0 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL defer_reti: redirect=%b pc=%h ackh=%b st=%b, want 1 00000200 0 0000",
               redirect, redirect_pc, ack_high, int_status);
    end
    idle_cycle();
    retire(1'b0, 32'h300);
    interrupt_pin_high = 1'b0;
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h08 || ack_high !== 1'b1 || int_status !== 4'b0010) begin
      tests_failed++;
      $display("FAIL defer_high: redirect=%b pc=%h ackh=%b st=%b, want 1 00000008 1 0010",
               redirect, redirect_pc, ack_high, int_status);
    end
    idle_cycle();
    retire(1'b1, 32'h0C);
    tests_run++;
    if (redirect_pc !== 32'h300 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL defer_return: pc=%h st=%b, want 00000300 0000", redirect_pc, int_status);
    end
    idle_cycle();
  endtask

  task automatic test_spurious_and_masking();
    retire(1'b1, 32'h0);
    tests_run++;
    if (spurious_reti !== 1'b1 || redirect !== 1'b0 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL spurious: spur=%b redirect=%b st=%b, want 1 0 0000",
               spurious_reti, redirect, int_status);
    end
    idle_cycle();
    tests_run++;
    if (spurious_reti !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_pulse: spur=%b, want 0", spurious_reti);
    end
    // Low entry, then a reti strobe landing in the redirect cycle must be ignored.
    interrupt_pin_low = 1'b1;
    retire(1'b0, 32'h400);
    interrupt_pin_low = 1'b0;
    retire(1'b1, 32'h18);
    tests_run++;
    if (redirect !== 1'b0 || spurious_reti !== 1'b0 || int_status !== 4'b0001) begin
      tests_failed++;
      $display("FAIL redirect_mask: redirect=%b spur=%b st=%b, want 0 0 0001",
               redirect, spurious_reti, int_status);
    end
    retire(1'b1, 32'h1C);
    tests_run++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h400 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mask_return: redirect=%b pc=%h st=%b, want 1 00000400 0000",
               redirect, redirect_pc, int_status);
    end
    idle_cycle();
  endtask

  task automatic test_async_reset();
    interrupt_pin_low = 1'b1;
    retire(1'b0, 32'h500);
    interrupt_pin_low  = 1'b0;
    interrupt_pin_high = 1'b1;
    idle_cycle();
    retire(1'b0, 32'h600);
    interrupt_pin_high = 1'b0;
    tests_run++;
    if (int_status !== 4'b1011 || redirect !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_nest: st=%b redirect=%b, want 1011 1", int_status, redirect);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (redirect !== 1'b0 || redirect_pc !== 32'h0 || ack_high !== 1'b0 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL async_reset: redirect=%b pc=%h ackh=%b st=%b, want 0 00000000 0 0000",
               redirect, redirect_pc, ack_high, int_status);
    end
    #2;
    rst_n = 1'b1;
    idle_cycle();
    retire(1'b0, 32'h700);
    tests_run++;
    if (redirect !== 1'b0 || spurious_reti !== 1'b0 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset: redirect=%b spur=%b st=%b, want 0 0 0000",
               redirect, spurious_reti, int_status);
    end
  endtask

  initial begin
    test_reset();
    test_low_entry();
    retire(1'b1, 32'h0);
    tests_run++;
    if (redirect_pc !== 32'h100 || int_status !== 4'b0000) begin
      tests_failed++;
      $display("FAIL low_return: pc=%h st=%b, want 00000100 0000", redirect_pc, int_status);
    end
    idle_cycle();
    interrupt_pin_low = 1'b1;
    retire(1'b0, 32'h100);
    interrupt_pin_low = 1'b0;
    idle_cycle();
    test_nesting();
    test_both_pins();
    test_deferred_high();
    test_spurious_and_masking();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
